// File: rtl/mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq
// Purpose  : Sequences a multiply-accumulate over count operand pairs. It
//            fetches each pair from the register file, drives the arith
//            controls, drains the macop pipeline, then loads the result.
// Revision : 1.0 - initial release
// ============================================================================
module mac_seq #(
  parameter int MAXN = 32
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] count,
  input  logic       sgn,
  input  logic       hisel,
  input  logic       abort,
  output logic       opreq,
  output logic [5:0] opidx,
  input  logic       opack,
  output logic       macop,
  output logic       multsel,
  output logic       multsign,
  output logic       resld,
  output logic [2:0] ressel,
  output logic       flagld,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] c_maxn    = 6'(MAXN);
  localparam logic [2:0] c_sel_acc = 3'b011;
  localparam logic [2:0] c_sel_res = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     r_state;
  logic [5:0] r_n;
  logic [5:0] r_count;
  logic       r_sgn;
  logic       r_hisel;
  logic       r_drain;

  logic [5:0] w_n_next;
  logic       w_last;
  logic       w_count_ok;

  assign w_n_next   = r_n + 6'd1;
  assign w_last     = (w_n_next >= r_count);
  assign w_count_ok = (count != 6'd0) && (count <= c_maxn);

  // Every output is registered: control outputs reflect the action taken in
  // the previous cycle, while busy/opreq/opidx track the state being entered.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_n      <= 6'd0;
      r_count  <= 6'd0;
      r_sgn    <= 1'b0;
      r_hisel  <= 1'b0;
      r_drain  <= 1'b0;
      opreq    <= 1'b0;
      opidx    <= 6'd0;
      macop    <= 1'b0;
      multsel  <= 1'b0;
      multsign <= 1'b0;
      resld    <= 1'b0;
      ressel   <= c_sel_res;
      flagld   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      macop    <= 1'b0;
      multsel  <= 1'b0;
      multsign <= 1'b0;
      resld    <= 1'b0;
      ressel   <= c_sel_res;
      flagld   <= 1'b0;
      done     <= 1'b0;

      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_n     <= 6'd0;
        r_drain <= 1'b0;
        opreq   <= 1'b0;
        opidx   <= 6'd0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              busy <= 1'b1;
              if (w_count_ok) begin
                r_count <= count;
                r_sgn   <= sgn;
                r_hisel <= hisel;
                r_n     <= 6'd0;
                opreq   <= 1'b1;
                opidx   <= 6'd0;
                r_state <= S_FETCH;
              end else begin
                r_state <= S_DONE;
              end
            end
          end

          S_FETCH: begin
            if (opack) begin
              multsel  <= r_hisel;
              multsign <= r_sgn;
              ressel   <= c_sel_acc;
              if (r_n == 6'd0) begin
                resld <= 1'b1;
              end else begin
                macop <= 1'b1;
              end
              r_n <= w_n_next;
              if (w_last) begin
                opreq   <= 1'b0;
                opidx   <= 6'd0;
                r_drain <= 1'b0;
                // A single term has nothing in the macop pipeline to drain.
                r_state <= (r_count == 6'd1) ? S_FINAL : S_DRAIN;
              end else begin
                opidx <= w_n_next;
              end
            end
          end

          S_DRAIN: begin
            if (r_drain) begin
              r_drain <= 1'b0;
              r_state <= S_FINAL;
            end else begin
              r_drain <= 1'b1;
            end
          end

          S_FINAL: begin
            resld   <= 1'b1;
            ressel  <= c_sel_res;
            flagld  <= 1'b1;
            r_state <= S_DONE;
          end

          S_DONE: begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_n     <= 6'd0;
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            opreq   <= 1'b0;
            opidx   <= 6'd0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_seq
// Purpose  : Self-checking bench for mac_seq: per-cycle comparison against an
//            action-queue model, plus hand-computed latency/pulse counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_seq;

  localparam int MAXN    = 32;
  localparam int A_NONE  = 0;
  localparam int A_FINAL = 1;
  localparam int A_DONE  = 2;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       start   = 1'b0;
  logic [5:0] count   = 6'd0;
  logic       sgn     = 1'b0;
  logic       hisel   = 1'b0;
  logic       abort   = 1'b0;
  logic       opack   = 1'b0;
  logic       opreq, macop, multsel, multsign, resld, flagld, busy, done;
  logic [5:0] opidx;
  logic [2:0] ressel;

  mac_seq #(.MAXN(MAXN)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (start),
    .count   (count),
    .sgn     (sgn),
    .hisel   (hisel),
    .abort   (abort),
    .opreq   (opreq),
    .opidx   (opidx),
    .opack   (opack),
    .macop   (macop),
    .multsel (multsel),
    .multsign(multsign),
    .resld   (resld),
    .ressel  (ressel),
    .flagld  (flagld),
    .busy    (busy),
    .done    (done)
  );

  always #5 sys_clk = ~sys_clk;

  // 0: never ack, 1: ack held high, 2: ack one cycle after each request
  int ack_mode = 0;
  always @(posedge sys_clk) begin : p_ack
    logic prev_req;
    #2;
    case (ack_mode)
      1:       opack = 1'b1;
      2:       opack = prev_req & ~opack;
      default: opack = 1'b0;
    endcase
    prev_req = opreq;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model expectations for the current cycle.
  logic       e_busy = 0, e_opreq = 0, e_macop = 0, e_multsel = 0, e_multsign = 0;
  logic       e_resld = 0, e_flagld = 0, e_done = 0;
  logic [5:0] e_opidx = 0;
  logic [2:0] e_ressel = 0;
  bit         m_valid = 0;
  bit         m_fetch = 0;
  int         m_n = 0, m_cnt = 0;
  logic       m_sgn = 0, m_hi = 0;
  int         m_tail[$];

  // Observed-event tallies for the literal checks.
  int n_issue = 0, n_macop = 0, n_resld = 0, n_flag = 0, n_done = 0;
  int n_sgn_issue = 0, n_hi_issue = 0;
  int last_issue_cyc = 0, last_flag_cyc = 0, last_done_cyc = 0;

  task automatic model_step();
    logic       b, rq, mo, ms, mg, rl, fl, dn;
    logic [5:0] ix;
    logic [2:0] rs;
    int         act;
    b = e_busy; rq = 0; ix = 0; mo = 0; ms = 0; mg = 0; rl = 0; rs = 0; fl = 0; dn = 0;
    if (reset) begin
      m_valid = 1; m_fetch = 0; m_tail.delete(); b = 0;
    end else if (!e_busy) begin
      if (start) begin
        b = 1;
        if (count >= 6'd1 && int'(count) <= MAXN) begin
          m_fetch = 1; m_n = 0; m_cnt = int'(count); m_sgn = sgn; m_hi = hisel;
          rq = 1; ix = 0;
        end else begin
          m_tail = '{A_DONE};
        end
      end
    end else if (abort) begin
      m_fetch = 0; m_tail.delete(); b = 0;
    end else if (m_fetch) begin
      if (opack) begin
        rs = 3'b011; ms = m_hi; mg = m_sgn;
        if (m_n == 0) rl = 1; else mo = 1;
        m_n++;
        if (m_n < m_cnt) begin
          rq = 1; ix = 6'(m_n);
        end else begin
          m_fetch = 0;
          if (m_cnt == 1) m_tail = '{A_FINAL, A_DONE};
          else            m_tail = '{A_NONE, A_NONE, A_FINAL, A_DONE};
        end
      end else begin
        rq = 1; ix = 6'(m_n);
      end
    end else if (m_tail.size() != 0) begin
      act = m_tail.pop_front();
      if (act == A_FINAL) begin rl = 1; fl = 1; rs = 3'b000; end
      if (act == A_DONE) dn = 1;
      b = (m_tail.size() != 0);
    end else begin
      b = 0;
    end
    e_busy = b; e_opreq = rq; e_opidx = ix; e_macop = mo; e_multsel = ms;
    e_multsign = mg; e_resld = rl; e_ressel = rs; e_flagld = fl; e_done = dn;
  endtask

  task automatic monitor_step();
    logic [16:0] got, want;
    logic        iss;
    got  = {busy, opreq, opidx, macop, multsel, multsign, resld, ressel, flagld, done};
    want = {e_busy, e_opreq, e_opidx, e_macop, e_multsel, e_multsign, e_resld, e_ressel,
            e_flagld, e_done};
    if (m_valid) begin
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle %0d outputs {busy,opreq,opidx,macop,msel,msgn,resld,ressel,flagld,done}: got %b want %b",
                 cyc, got, want);
      end
    end
    iss = (ressel == 3'b011) && (macop || resld);
    if (iss) begin
      n_issue++; last_issue_cyc = cyc;
      if (multsign) n_sgn_issue++;
      if (multsel)  n_hi_issue++;
    end
    if (macop)  n_macop++;
    if (resld)  n_resld++;
    if (flagld) begin n_flag++; last_flag_cyc = cyc; end
    if (done)   begin n_done++; last_done_cyc = cyc; end
    model_step();
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  int start_cyc;
  int b_issue, b_macop, b_resld, b_flag, b_done, b_sgn, b_hi;

  task automatic snap();
    b_issue = n_issue; b_macop = n_macop; b_resld = n_resld; b_flag = n_flag;
    b_done = n_done; b_sgn = n_sgn_issue; b_hi = n_hi_issue;
  endtask

  task automatic run_start(input int c, input logic s, input logic h);
    snap();
    start = 1; count = 6'(c); sgn = s; hisel = h;
    start_cyc = cyc;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int k;
    k = 0;
    while (n_done == b_done && k < bound) begin
      tick();
      k++;
    end
    chk({name, "_timeout"}, int'(k < bound), 1);
    tick();
    tick();
  endtask

  initial begin
    fork
      forever begin
        @(negedge sys_clk);
        monitor_step();
      end
    join_none

    repeat (3) tick();
    reset = 0;
    chk("reset_outputs", int'({busy, opreq, opidx, macop, multsel, multsign, resld, ressel, flagld, done}), 0);

    // count=3, signed, ack one cycle after each request
    ack_mode = 2;
    run_start(3, 1'b1, 1'b0);
    wait_done("c3", 60);
    chk("c3_issues",        n_issue - b_issue, 3);
    chk("c3_macop_terms",   n_macop - b_macop, 2);
    chk("c3_resld_pulses",  n_resld - b_resld, 2);
    chk("c3_flagld_pulses", n_flag - b_flag, 1);
    chk("c3_signed_issues", n_sgn_issue - b_sgn, 3);
    chk("c3_done_pulses",   n_done - b_done, 1);
    chk("c3_final_to_done", last_done_cyc - last_flag_cyc, 1);
    chk("c3_issue_to_final", last_flag_cyc - last_issue_cyc, 3);

    // count=4, ack held high
    ack_mode = 1;
    run_start(4, 1'b0, 1'b0);
    wait_done("c4", 60);
    chk("c4_latency", last_done_cyc - start_cyc, 9);
    chk("c4_issues",  n_issue - b_issue, 4);

    // count=0 and count above MAXN: immediate done, no controls
    run_start(0, 1'b0, 1'b0);
    wait_done("c0", 20);
    chk("c0_latency",  last_done_cyc - start_cyc, 2);
    chk("c0_controls", (n_macop - b_macop) + (n_resld - b_resld), 0);
    run_start(MAXN + 1, 1'b0, 1'b0);
    wait_done("cbig", 20);
    chk("cbig_latency", last_done_cyc - start_cyc, 2);
    chk("cbig_issues",  n_issue - b_issue, 0);

    // count=MAXN, the largest accepted sequence
    run_start(MAXN, 1'b1, 1'b1);
    wait_done("cmax", 100);
    chk("cmax_latency", last_done_cyc - start_cyc, MAXN + 5);
    chk("cmax_issues",  n_issue - b_issue, MAXN);

    // count=1: no drain, FINAL right after the single issue
    run_start(1, 1'b0, 1'b1);
    wait_done("c1", 20);
    chk("c1_latency",        last_done_cyc - start_cyc, 4);
    chk("c1_issues",         n_issue - b_issue, 1);
    chk("c1_hisel_issues",   n_hi_issue - b_hi, 1);
    chk("c1_issue_to_final", last_flag_cyc - last_issue_cyc, 1);

    // abort coincident with the term-2 ack of a 5-term sequence
    run_start(5, 1'b0, 1'b0);
    begin
      int k;
      k = 0;
      while (!(opreq && opidx == 6'd2) && k < 20) begin
        tick();
        k++;
      end
      chk("abort_reach_term2", int'(k < 20), 1);
    end
    abort = 1;
    tick();
    abort = 0;
    chk("abort_busy_low", int'(busy), 0);
    repeat (6) tick();
    chk("abort_issues", n_issue - b_issue, 2);
    chk("abort_no_done", n_done - b_done, 0);

    // abort in IDLE is harmless; a new start is accepted afterwards
    abort = 1;
    tick();
    abort = 0;
    run_start(2, 1'b0, 1'b0);
    wait_done("c2", 30);
    chk("c2_latency", last_done_cyc - start_cyc, 7);

    // reset pulsed while draining
    run_start(3, 1'b0, 1'b0);
    repeat (3) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_outputs", int'({busy, opreq, opidx, macop, multsel, multsign, resld, ressel, flagld, done}), 0);
    repeat (8) tick();
    chk("rst_no_done", n_done - b_done, 0);

    // a start while busy is neither honoured nor queued
    ack_mode = 2;
    run_start(3, 1'b0, 1'b0);
    tick();
    start = 1; count = 6'd1;
    tick();
    start = 0;
    wait_done("busy_start", 60);
    repeat (10) tick();
    chk("busy_start_issues", n_issue - b_issue, 3);
    chk("busy_start_done",   n_done - b_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
